// File: rtl/muldiv_unit_if.sv
// ---------------------------------------------------------------------------
// muldiv_unit_if
// Request/response bundle between the EX stage and the iterative
// multiply/divide unit.
//   start_i    : request a new operation
//   op_i       : 00 MULTU, 01 MULT, 10 DIVU, 11 DIV (bit0 = signed)
//   opdata1_i  : multiplicand / dividend
//   opdata2_i  : multiplier / divisor
//   annul_i    : abort the in-flight operation (pipeline flush)
//   result_o   : {HI, LO} result
//   ready_o    : one-cycle pulse, result_o valid from this cycle on
//   busy_o     : unit is calculating, EX stage stalls
//   div_zero_o : last divide had a zero divisor
// Modports: master = EX stage side, slave = muldiv_unit side.
// ---------------------------------------------------------------------------
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic                   start_i;
    logic [1:0]             op_i;
    logic [WIDTH-1:0]       opdata1_i;
    logic [WIDTH-1:0]       opdata2_i;
    logic                   annul_i;
    logic [2*WIDTH-1:0]     result_o;
    logic                   ready_o;
    logic                   busy_o;
    logic                   div_zero_o;

    modport master (
        output start_i, op_i, opdata1_i, opdata2_i, annul_i,
        input  result_o, ready_o, busy_o, div_zero_o
    );

    modport slave (
        input  start_i, op_i, opdata1_i, opdata2_i, annul_i,
        output result_o, ready_o, busy_o, div_zero_o
    );
endinterface

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Iterative signed/unsigned multiply and divide for the EX stage. One
// radix-2 step per cycle (restoring divide, shift-add multiply) on
// magnitudes, followed by a sign-fix cycle. Result is {HI, LO}.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous reset, active-high
//   bus : muldiv_unit_if slave modport (start/op/operands/annul in,
//         result/ready/busy/div_zero out)
// Parameters:
//   WIDTH : operand width, result is 2*WIDTH
//   CNT_W : iteration counter width, 2**CNT_W > WIDTH
// Configuration macro:
//   MULDIV_FAST_MUL_EN : multiplies use one combinational WIDTHxWIDTH
//                        product at the start edge; divide unchanged.
// ---------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic                 is_div;
    logic                 sign_q;       // quotient / product must be negated
    logic                 sign_r;       // remainder must be negated
    logic                 fast_pend;    // direct result waiting for its ready pulse
    logic [WIDTH-1:0]     operand;      // |divisor| or |multiplicand|
    logic [2*WIDTH-1:0]   acc;          // {rem, quo} or {prod_hi, prod_lo/multiplier}

    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [WIDTH:0]       rem_ext, rem_diff, mul_sum;
    logic [2*WIDTH-1:0]   div_next, mul_next, fix_div, fix_mul;
    logic [WIDTH-1:0]     quo, rem;

    // NOTE: every signal gets a value on every path, so no latch is inferred.
    always_comb begin
        a_neg = bus.op_i[0] & bus.opdata1_i[WIDTH-1];
        b_neg = bus.op_i[0] & bus.opdata2_i[WIDTH-1];
        abs_a = a_neg ? -bus.opdata1_i : bus.opdata1_i;
        abs_b = b_neg ? -bus.opdata2_i : bus.opdata2_i;
    end

    always_comb begin
        // Divide step: shifted remainder needs WIDTH+1 bits; the borrow bit
        // of the trial subtraction tells whether the divisor fits.
        rem_ext  = acc[2*WIDTH-1:WIDTH-1];
        rem_diff = rem_ext - {1'b0, operand};
        if (!rem_diff[WIDTH])
            div_next = {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            div_next = {rem_ext[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

        // Multiply step: add multiplicand into the high half when the
        // multiplier LSB is set, then shift the whole accumulator right.
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};

        quo      = acc[WIDTH-1:0];
        rem      = acc[2*WIDTH-1:WIDTH];
        fix_div  = {(sign_r ? -rem : rem), (sign_q ? -quo : quo)};
        fix_mul  = sign_q ? -acc : acc;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] ext_a, ext_b, fast_prod;

    // Sign- or zero-extend to 2*WIDTH; the low 2*WIDTH bits of the product
    // are then the correct signed or unsigned result.
    always_comb begin
        ext_a     = {{WIDTH{a_neg}}, bus.opdata1_i};
        ext_b     = {{WIDTH{b_neg}}, bus.opdata2_i};
        fast_prod = ext_a * ext_b;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: datapath registers are reset as well; result_o must read 0 after reset.
            state          <= IDLE;
            cnt            <= '0;
            is_div         <= 1'b0;
            sign_q         <= 1'b0;
            sign_r         <= 1'b0;
            fast_pend      <= 1'b0;
            operand        <= '0;
            acc            <= '0;
            bus.result_o   <= '0;
            bus.ready_o    <= 1'b0;
            bus.busy_o     <= 1'b0;
            bus.div_zero_o <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            // A directly produced result raises ready_o one edge after it is stored.
            fast_pend   <= 1'b0;
            bus.ready_o <= fast_pend;
            case (state)
                IDLE, DONE: begin
                    state       <= IDLE;
                    bus.busy_o  <= 1'b0;
                    if (bus.start_i && !bus.annul_i) begin
                        is_div <= bus.op_i[1];
                        sign_q <= a_neg ^ b_neg;
                        sign_r <= a_neg;
                        cnt    <= '0;
                        if (bus.op_i[1] && bus.opdata2_i == '0) begin
                            bus.result_o   <= {bus.opdata1_i, {WIDTH{1'b1}}};
                            bus.div_zero_o <= 1'b1;
                            fast_pend      <= 1'b1;
                            state          <= DONE;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        else if (!bus.op_i[1]) begin
                            bus.result_o   <= fast_prod;
                            bus.div_zero_o <= 1'b0;
                            fast_pend      <= 1'b1;
                            state          <= DONE;
                        end
`endif
                        else begin
                            operand    <= bus.op_i[1] ? abs_b : abs_a;
                            acc        <= {{WIDTH{1'b0}}, (bus.op_i[1] ? abs_a : abs_b)};
                            bus.busy_o <= 1'b1;
                            state      <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (bus.annul_i) begin
                        bus.busy_o <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        acc <= is_div ? div_next : mul_next;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(WIDTH - 1))
                            state <= FIX;
                    end
                end
                FIX: begin
                    bus.busy_o <= 1'b0;
                    if (bus.annul_i) begin
                        state <= IDLE;
                    end else begin
                        bus.result_o   <= is_div ? fix_div : fix_mul;
                        bus.div_zero_o <= 1'b0;
                        bus.ready_o    <= 1'b1;
                        state          <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
